// File: rtl/prio_arbiter_amisha.sv
// Registered N-input priority arbiter with held grants, fixed or round-robin selection.
// Optional hold timeout when PRIO_HOLD_TIMEOUT_EN is defined.
module prio_arbiter_amisha #(
  parameter int N        = 4,
  parameter int IDXW     = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk_amisha,
  input  logic            reset_amisha,
  input  logic [N-1:0]    req_amisha,
  input  logic            rr_mode_amisha,
  output logic [IDXW-1:0] y_amisha,
  output logic [N-1:0]    grant_amisha,
  output logic            valid_amisha
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e          state_q, state_d;
  logic [IDXW-1:0] y_q, y_d, ptr_q, ptr_d, win;
  logic [N-1:0]    grant_q, grant_d, arb_req;
  logic            valid_q, valid_d, do_arb, timeout;

`ifdef PRIO_HOLD_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  // Returns the 1-based winning index, 0 when r is empty. Round-robin searches
  // downward from ptr-1, wrapping from 1 to N; ptr 0 or 1 both start at N.
  function automatic logic [IDXW-1:0] pick(input logic [N-1:0] r, input logic rr,
                                           input logic [IDXW-1:0] ptr);
    logic [IDXW-1:0] w;
    logic            found;
    int              start, idx;
    w     = '0;
    found = 1'b0;
    if (!rr) begin
      for (int k = 1; k <= N; k++)
        if (r[k-1]) w = IDXW'(k);
    end else begin
      start = (ptr <= IDXW'(1)) ? N : int'(ptr) - 1;
      for (int i = 0; i < N; i++) begin
        idx = start - i;
        if (idx < 1) idx = idx + N;
        if (!found && r[idx-1]) begin
          w     = IDXW'(idx);
          found = 1'b1;
        end
      end
    end
    return w;
  endfunction

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    grant_d = grant_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    arb_req = req_amisha;
    do_arb  = 1'b0;
    timeout = 1'b0;
`ifdef PRIO_HOLD_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif

    if (state_q == IDLE || (req_amisha & grant_q) == '0) begin
      do_arb = 1'b1;
    end else begin
`ifdef PRIO_HOLD_TIMEOUT_EN
      if (cnt_q == CW'(MAX_HOLD)) begin
        do_arb  = 1'b1;
        timeout = 1'b1;
        arb_req = req_amisha & ~grant_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
`endif
    end

    win = pick(arb_req, rr_mode_amisha, ptr_q);

    if (do_arb) begin
      if (win != '0) begin
        state_d = BUSY;
        y_d     = win;
        grant_d = N'(1) << (win - 1'b1);
        valid_d = 1'b1;
        ptr_d   = win;
`ifdef PRIO_HOLD_TIMEOUT_EN
        cnt_d   = CW'(1);
`endif
      end else if (timeout) begin
        // Nobody else is asking: the current grantee keeps it with a fresh count.
        ptr_d   = y_q;
`ifdef PRIO_HOLD_TIMEOUT_EN
        cnt_d   = CW'(1);
`endif
      end else begin
        state_d = IDLE;
        y_d     = '0;
        grant_d = '0;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      state_q <= IDLE;
      y_q     <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
`ifdef PRIO_HOLD_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
`ifdef PRIO_HOLD_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign y_amisha     = y_q;
  assign grant_amisha = grant_q;
  assign valid_amisha = valid_q;

endmodule

// File: tb/tb_prio_arbiter_amisha.sv
// Bench for prio_arbiter_amisha: directed scenarios plus randomized traffic against a reference model.
module tb_prio_arbiter_amisha;
  localparam int N = 4, IDXW = 3, MH = 4;

  logic            clk = 1'b0, rst = 1'b1, rr = 1'b0;
  logic [N-1:0]    req = '0;
  logic [IDXW-1:0] y;
  logic [N-1:0]    gnt;
  logic            vld;
  int              n_cmp = 0, n_bad = 0;
  int              m_cur = 0, m_ptr = 0, m_cnt = 0;

  prio_arbiter_amisha #(.N(N), .IDXW(IDXW), .MAX_HOLD(MH)) dut (
    .clk_amisha(clk), .reset_amisha(rst), .req_amisha(req), .rr_mode_amisha(rr),
    .y_amisha(y), .grant_amisha(gnt), .valid_amisha(vld));

  always #5 clk = ~clk;

  // Fixed: highest set channel. Round-robin: visit channels in descending
  // order starting just below the last winner (pointer 0 behaves like 1).
  function automatic int m_pick(input logic [N-1:0] r, input logic mode, input int ptr);
    int eff, k;
    if (!mode) begin
      for (int c = N; c >= 1; c--) if (r[c-1]) return c;
      return 0;
    end
    eff = (ptr == 0) ? 1 : ptr;
    for (int off = 1; off <= N; off++) begin
      k = (((eff - 1 - off) % N) + N) % N + 1;
      if (r[k-1]) return k;
    end
    return 0;
  endfunction

  function automatic logic [N+IDXW:0] m_out();
    logic [N-1:0] oh;
    oh = (m_cur == 0) ? '0 : N'(1) << (m_cur - 1);
    return {m_cur != 0, oh, IDXW'(m_cur)};
  endfunction

  // Drive one cycle, advance the model on the same edge, settle past the edge.
  task automatic step(input logic r_rst, input logic [N-1:0] r_req, input logic r_rr);
    int w;
    logic [N-1:0] held;
    rst = r_rst; req = r_req; rr = r_rr;
    @(posedge clk);
    held = (m_cur == 0) ? '0 : N'(1) << (m_cur - 1);
    if (r_rst) begin
      m_cur = 0; m_ptr = 0; m_cnt = 0;
    end else if (m_cur == 0 || (r_req & held) == '0) begin
      w = m_pick(r_req, r_rr, m_ptr);
      m_cur = w;
      if (w != 0) begin m_ptr = w; m_cnt = 1; end
    end
`ifdef PRIO_HOLD_TIMEOUT_EN
    else if (m_cnt == MH) begin
      w = m_pick(r_req & ~held, r_rr, m_ptr);
      if (w != 0) m_cur = w;
      m_ptr = m_cur; m_cnt = 1;
    end
`endif
    else m_cnt++;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'b1111, 1'b0);
      n_cmp++;
      if ({vld, gnt, y} !== 8'b0) begin
        n_bad++; $display("FAIL reset_hold: got v=%b g=%b y=%0d want 0/0000/0", vld, gnt, y);
      end
    end
    step(1'b0, 4'b1111, 1'b0);
    n_cmp++;
    if ({vld, gnt, y} !== {1'b1, 4'b1000, 3'd4}) begin
      n_bad++; $display("FAIL reset_release: got v=%b g=%b y=%0d want 1/1000/4", vld, gnt, y);
    end
  endtask

  task automatic test_fixed();
    logic [N-1:0] rq [4] = '{4'b0101, 4'b1101, 4'b1001, 4'b0000};
    logic [IDXW-1:0] ey [4] = '{3'd3, 3'd3, 3'd4, 3'd0};
    step(1'b1, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, rq[i], 1'b0);
      n_cmp++;
      if (y !== ey[i] || {vld, gnt, y} !== m_out()) begin
        n_bad++; $display("FAIL fixed[%0d]: got v=%b g=%b y=%0d want y=%0d model=%b", i, vld, gnt, y, ey[i], m_out());
      end
    end
  endtask

  task automatic test_back_to_back_rr();
    int ey [4] = '{3, 2, 1, 4};
    logic [N-1:0] drop;
    step(1'b1, '0, 1'b1);
    step(1'b0, 4'b1111, 1'b1);
    n_cmp++;
    if (y !== 3'd4 || vld !== 1'b1) begin
      n_bad++; $display("FAIL rr_first: got y=%0d v=%b want 4/1", y, vld);
    end
    for (int i = 0; i < 4; i++) begin
      drop = 4'b1111 & ~gnt;
      step(1'b0, drop, 1'b1);
      n_cmp++;
      if (y !== IDXW'(ey[i]) || vld !== 1'b1 || gnt !== N'(1) << (ey[i] - 1)) begin
        n_bad++; $display("FAIL rr_seq[%0d]: got y=%0d g=%b v=%b want y=%0d", i, y, gnt, vld, ey[i]);
      end
      if (i < 3) step(1'b0, 4'b1111, 1'b1);
    end
  endtask

  task automatic test_reset_mid_grant();
    step(1'b1, '0, 1'b1);
    step(1'b0, 4'b0010, 1'b1);
    n_cmp++;
    if (y !== 3'd2) begin n_bad++; $display("FAIL mid_setup: got y=%0d want 2", y); end
    step(1'b1, 4'b0010, 1'b1);
    n_cmp++;
    if ({vld, gnt, y} !== 8'b0) begin
      n_bad++; $display("FAIL mid_reset: got v=%b g=%b y=%0d want 0/0000/0", vld, gnt, y);
    end
    step(1'b0, 4'b1111, 1'b1);
    n_cmp++;
    if (y !== 3'd4 || gnt !== 4'b1000) begin
      n_bad++; $display("FAIL mid_ptr_reset: got y=%0d g=%b want 4/1000", y, gnt);
    end
  endtask

  task automatic test_mode_switch();
    step(1'b1, '0, 1'b0);
    step(1'b0, 4'b1011, 1'b0);
    step(1'b0, 4'b1011, 1'b1);
    n_cmp++;
    if (y !== 3'd4 || vld !== 1'b1) begin n_bad++; $display("FAIL mode_hold: got y=%0d want 4", y); end
    step(1'b0, 4'b0011, 1'b1);
    n_cmp++;
    if (y !== 3'd2 || gnt !== 4'b0010) begin
      n_bad++; $display("FAIL mode_rr_next: got y=%0d g=%b want 2/0010", y, gnt);
    end
  endtask

`ifdef PRIO_HOLD_TIMEOUT_EN
  task automatic test_timeout();
    int ey;
    step(1'b1, '0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 4'b1001, 1'b0);
      ey = (i >= 4 && i < 8) ? 1 : 4;
      n_cmp++;
      if (y !== IDXW'(ey) || vld !== 1'b1) begin
        n_bad++; $display("FAIL timeout_swap[%0d]: got y=%0d want %0d", i, y, ey);
      end
    end
    step(1'b1, '0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'b0010, 1'b0);
      n_cmp++;
      if (y !== 3'd2 || vld !== 1'b1) begin
        n_bad++; $display("FAIL timeout_lone[%0d]: got y=%0d v=%b want 2/1", i, y, vld);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] r;
    logic m;
    step(1'b1, '0, 1'b0);
    r = '0; m = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) r = N'($urandom);
      if ($urandom_range(0, 9) == 0) m = ~m;
      step($urandom_range(0, 49) == 0, r, m);
      n_cmp++;
      if ({vld, gnt, y} !== m_out()) begin
        n_bad++; $display("FAIL random[%0d]: got v=%b g=%b y=%0d want %b", i, vld, gnt, y, m_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_back_to_back_rr();
    test_reset_mid_grant();
    test_mode_switch();
`ifdef PRIO_HOLD_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
